// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state codes,
// opcode values, datapath select codes and the opcode class type.
package mc_pkg;

  // State codes (also visible on the debug state output)
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_WB_MEM   = 4'd6;
  localparam logic [3:0] S_EXEC_R   = 4'd7;
  localparam logic [3:0] S_WB_R     = 4'd8;
  localparam logic [3:0] S_EXEC_I   = 4'd9;
  localparam logic [3:0] S_WB_I     = 4'd10;
  localparam logic [3:0] S_BRANCH   = 4'd11;
  localparam logic [3:0] S_JUMP     = 4'd12;

  typedef enum logic [3:0] {
    IDLE     = S_IDLE,
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEM_ADDR = S_MEM_ADDR,
    MEM_RD   = S_MEM_RD,
    MEM_WR   = S_MEM_WR,
    WB_MEM   = S_WB_MEM,
    EXEC_R   = S_EXEC_R,
    WB_R     = S_WB_R,
    EXEC_I   = S_EXEC_I,
    WB_I     = S_WB_I,
    BRANCH   = S_BRANCH,
    JUMP     = S_JUMP
  } stateT;

  // Opcode field values (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  // PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_J,
    CLS_ILL
  } opClassT;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM and the datapath: instruction/status
// inputs to the controller and every datapath select it drives.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       alu_zero;
  logic       mem_ready;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       ext_sel;
  logic       illegal;
  logic [3:0] state_o;

  // Controller side
  modport master (
    input  opcode, alu_zero, mem_ready,
    output ir_write, pc_write, pc_src, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, ext_sel, illegal, state_o
  );

  // Datapath side
  modport slave (
    output opcode, alu_zero, mem_ready,
    input  ir_write, pc_write, pc_src, iord, mem_read, mem_write,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_op, ext_sel, illegal, state_o
  );
endinterface

// File: rtl/opcode_class.sv
// Combinational opcode classifier: groups opcodes by the state sequence
// they need and flags ADDIU (sign-extended add) and unknown opcodes.
module opcode_class
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  output opClassT    opClass,
  output logic       isAddiu,
  output logic       legal
);

  // Map opcode to class; anything not listed is illegal
  always_comb begin
    opClass = CLS_ILL;
    isAddiu = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OP_RTYPE: opClass = CLS_R;
      OP_ADDIU: begin
        opClass = CLS_I;
        isAddiu = 1'b1;
      end
      OP_ANDI, OP_ORI: opClass = CLS_I;
      OP_LW:    opClass = CLS_LW;
      OP_SW:    opClass = CLS_SW;
      OP_BEQ:   opClass = CLS_BEQ;
      OP_J:     opClass = CLS_J;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle MIPS datapath. The state register is the
// only storage; outputs decode the state, with the FETCH/BRANCH strobes and
// the illegal pulse also depending on mem_ready, alu_zero and the opcode.
module multicycle_control
  import mc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  multicycle_control_if.master bus
);

  stateT   state, stateNext;
  opClassT opClass;
  logic    isAddiu, legal;

  logic       irWrite, pcWrite, iord, memRead, memWrite;
  logic       regWrite, regDst, memToReg, aluSrcA, extSel, illegal;
  logic [1:0] pcSrc, aluSrcB, aluOp;

  opcode_class uOpClass (
    .opcode (bus.opcode),
    .opClass(opClass),
    .isAddiu(isAddiu),
    .legal  (legal)
  );

  // State register; reset drops any outstanding memory request at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and output decode; every output defaults to 0
  always_comb begin
    stateNext = state;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = PC_ALU;
    iord      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_B;
    aluOp     = ALU_ADD;
    extSel    = 1'b0;
    illegal   = 1'b0;
    case (state)
      IDLE: stateNext = FETCH;
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_FOUR;
        aluOp   = ALU_ADD;
        if (bus.mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          pcSrc     = PC_ALU;
          stateNext = DECODE;
        end
      end
      DECODE: begin
        // Branch target precomputed here as PC+4 + (sext imm << 2)
        aluSrcB = SRCB_IMMSH;
        extSel  = 1'b1;
        if (!legal) begin
          illegal   = 1'b1;
          stateNext = FETCH;
        end else begin
          case (opClass)
            CLS_R:          stateNext = EXEC_R;
            CLS_I:          stateNext = EXEC_I;
            CLS_LW, CLS_SW: stateNext = MEM_ADDR;
            CLS_BEQ:        stateNext = BRANCH;
            CLS_J:          stateNext = JUMP;
            default: begin
              illegal   = 1'b1;
              stateNext = FETCH;
            end
          endcase
        end
      end
      MEM_ADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = SRCB_IMM;
        extSel    = 1'b1;
        stateNext = (opClass == CLS_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        memRead = 1'b1;
        iord    = 1'b1;
        if (bus.mem_ready) stateNext = WB_MEM;
      end
      MEM_WR: begin
        memWrite = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) stateNext = FETCH;
      end
      WB_MEM: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        stateNext = FETCH;
      end
      EXEC_R: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_FUNCT;
        stateNext = WB_R;
      end
      WB_R: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        stateNext = FETCH;
      end
      EXEC_I, WB_I: begin
        // ALU inputs held into write-back so the result stays valid
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        extSel  = isAddiu;
        aluOp   = isAddiu ? ALU_ADD : ALU_LOGIC;
        if (state == EXEC_I) begin
          stateNext = WB_I;
        end else begin
          regWrite  = 1'b1;
          stateNext = FETCH;
        end
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_SUB;
        pcSrc     = PC_ALUOUT;
        pcWrite   = bus.alu_zero;
        stateNext = FETCH;
      end
      JUMP: begin
        pcSrc     = PC_JUMP;
        pcWrite   = 1'b1;
        stateNext = FETCH;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.ir_write   = irWrite;
  assign bus.pc_write   = pcWrite;
  assign bus.pc_src     = pcSrc;
  assign bus.iord       = iord;
  assign bus.mem_read   = memRead;
  assign bus.mem_write  = memWrite;
  assign bus.reg_write  = regWrite;
  assign bus.reg_dst    = regDst;
  assign bus.mem_to_reg = memToReg;
  assign bus.alu_src_a  = aluSrcA;
  assign bus.alu_src_b  = aluSrcB;
  assign bus.alu_op     = aluOp;
  assign bus.ext_sel    = extSel;
  assign bus.illegal    = illegal;
  assign bus.state_o    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control trace, which is then
// driven and compared cycle by cycle.
module tb_multicycle_control;
  import mc_pkg::*;

  typedef struct packed {
    logic       irW;
    logic       pcW;
    logic [1:0] pcSrc;
    logic       iord;
    logic       mRd;
    logic       mWr;
    logic       regW;
    logic       regDst;
    logic       m2r;
    logic       srcA;
    logic [1:0] srcB;
    logic [1:0] aluOp;
    logic       ext;
    logic       ill;
  } ctlT;

  typedef struct {
    ctlT        e;
    logic [3:0] st;
    logic       mr;
    logic       az;
    logic [5:0] op;
  } cycT;

  logic clk = 1'b0;
  logic rst_n;
  int   nChecks = 0;
  int   nFail   = 0;
  cycT  plan[$];

  always #5 clk = ~clk;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctlT observed();
    ctlT o;
    o.irW    = bus.ir_write;
    o.pcW    = bus.pc_write;
    o.pcSrc  = bus.pc_src;
    o.iord   = bus.iord;
    o.mRd    = bus.mem_read;
    o.mWr    = bus.mem_write;
    o.regW   = bus.reg_write;
    o.regDst = bus.reg_dst;
    o.m2r    = bus.mem_to_reg;
    o.srcA   = bus.alu_src_a;
    o.srcB   = bus.alu_src_b;
    o.aluOp  = bus.alu_op;
    o.ext    = bus.ext_sel;
    o.ill    = bus.illegal;
    return o;
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic push(input ctlT e, input logic [3:0] st, input logic mr,
                      input logic az, input logic [5:0] op);
    cycT c;
    c.e = e; c.st = st; c.mr = mr; c.az = az; c.op = op;
    plan.push_back(c);
  endtask

  // Expand one instruction into its expected cycle trace.
  // fw/mw: wait cycles before mem_ready in fetch / data access.
  task automatic planInstr(input logic [5:0] op, input int fw, input int mw, input logic az);
    ctlT  e;
    logic isLegal;
    logic logical;
    isLegal = op inside {OP_RTYPE, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J};
    // Fetch: opcode not yet valid, drive junk on it
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mRd = 1'b1; e.srcB = 2'b01;
      push(e, S_FETCH, 1'b0, rbit(), 6'($urandom));
    end
    e = '0; e.mRd = 1'b1; e.srcB = 2'b01; e.irW = 1'b1; e.pcW = 1'b1;
    push(e, S_FETCH, 1'b1, rbit(), 6'($urandom));
    e = '0; e.srcB = 2'b11; e.ext = 1'b1; e.ill = !isLegal;
    push(e, S_DECODE, rbit(), rbit(), op);
    case (op)
      OP_RTYPE: begin
        e = '0; e.srcA = 1'b1; e.aluOp = 2'b10;
        push(e, S_EXEC_R, rbit(), rbit(), op);
        e = '0; e.regW = 1'b1; e.regDst = 1'b1;
        push(e, S_WB_R, rbit(), rbit(), op);
      end
      OP_ADDIU, OP_ANDI, OP_ORI: begin
        logical = (op != OP_ADDIU);
        e = '0; e.srcA = 1'b1; e.srcB = 2'b10; e.ext = !logical;
        e.aluOp = logical ? 2'b11 : 2'b00;
        push(e, S_EXEC_I, rbit(), rbit(), op);
        e.regW = 1'b1;
        push(e, S_WB_I, rbit(), rbit(), op);
      end
      OP_LW, OP_SW: begin
        e = '0; e.srcA = 1'b1; e.srcB = 2'b10; e.ext = 1'b1;
        push(e, S_MEM_ADDR, rbit(), rbit(), op);
        e = '0; e.iord = 1'b1;
        if (op == OP_LW) e.mRd = 1'b1; else e.mWr = 1'b1;
        for (int i = 0; i <= mw; i++)
          push(e, (op == OP_LW) ? S_MEM_RD : S_MEM_WR, (i == mw), rbit(), op);
        if (op == OP_LW) begin
          e = '0; e.regW = 1'b1; e.m2r = 1'b1;
          push(e, S_WB_MEM, rbit(), rbit(), op);
        end
      end
      OP_BEQ: begin
        e = '0; e.srcA = 1'b1; e.aluOp = 2'b01; e.pcSrc = 2'b01; e.pcW = az;
        push(e, S_BRANCH, rbit(), az, op);
      end
      OP_J: begin
        e = '0; e.pcSrc = 2'b10; e.pcW = 1'b1;
        push(e, S_JUMP, rbit(), rbit(), op);
      end
      default: ;
    endcase
  endtask

  // Drive and check up to n planned cycles (n < 0: all of them)
  task automatic runPlan(input string tag, input int n);
    cycT c;
    int  k = 0;
    while (plan.size() > 0 && (n < 0 || k < n)) begin
      c = plan.pop_front();
      @(negedge clk);
      bus.mem_ready = c.mr;
      bus.alu_zero  = c.az;
      bus.opcode    = c.op;
      #1;
      checkVal({tag, "_ctl"}, 32'(observed()), 32'(c.e));
      checkVal({tag, "_state"}, 32'(bus.state_o), 32'(c.st));
      k++;
    end
  endtask

  task automatic runInstr(input string tag, input logic [5:0] op, input int fw,
                          input int mw, input logic az);
    planInstr(op, fw, mw, az);
    runPlan(tag, -1);
  endtask

  logic [5:0] legalOps [8] = '{OP_RTYPE, OP_ADDIU, OP_ANDI, OP_ORI,
                                OP_LW, OP_SW, OP_BEQ, OP_J};

  initial begin
    logic [5:0] op;
    rst_n         = 1'b0;
    bus.opcode    = '0;
    bus.alu_zero  = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset: all outputs low, state IDLE
    repeat (2) @(negedge clk);
    #1;
    checkVal("rst_ctl", 32'(observed()), 32'h0);
    checkVal("rst_state", 32'(bus.state_o), 32'(S_IDLE));
    rst_n = 1'b1;
    #1;
    checkVal("idle_ctl", 32'(observed()), 32'h0);
    checkVal("idle_state", 32'(bus.state_o), 32'(S_IDLE));

    // Directed instructions
    runInstr("addiu", OP_ADDIU, 0, 0, 1'b0);
    runInstr("ori", OP_ORI, 0, 0, 1'b0);
    runInstr("andi", OP_ANDI, 1, 0, 1'b0);
    runInstr("rtype", OP_RTYPE, 0, 0, 1'b0);
    runInstr("lw_wait3", OP_LW, 0, 3, 1'b0);
    runInstr("sw_wait2", OP_SW, 2, 2, 1'b0);
    runInstr("beq_taken", OP_BEQ, 0, 0, 1'b1);
    runInstr("beq_not", OP_BEQ, 0, 0, 1'b0);
    runInstr("jump", OP_J, 0, 0, 1'b0);
    runInstr("illegal", 6'b111111, 0, 0, 1'b0);

    // Reset asserted while a load is waiting in MEM_RD
    planInstr(OP_LW, 0, 6, 1'b0);
    runPlan("lw_pre_rst", 5);
    plan.delete();
    #2;
    rst_n         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    checkVal("midrst_ctl", 32'(observed()), 32'h0);
    checkVal("midrst_state", 32'(bus.state_o), 32'(S_IDLE));
    @(negedge clk);
    #1;
    checkVal("midrst_hold_state", 32'(bus.state_o), 32'(S_IDLE));
    rst_n = 1'b1;
    #1;
    checkVal("post_rst_idle_ctl", 32'(observed()), 32'h0);
    checkVal("post_rst_idle_state", 32'(bus.state_o), 32'(S_IDLE));
    runInstr("post_rst_addiu", OP_ADDIU, 0, 0, 1'b0);

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else                           op = legalOps[$urandom_range(0, 7)];
      runInstr("rand", op, $urandom_range(0, 2), $urandom_range(0, 3), rbit());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
